// File: rtl/data_mem_block_mover_if.sv
// Bus bundle for the block mover: control-side request/status plus the
// single data-memory access port the mover drives while busy.
interface data_mem_block_mover_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              start;
   logic              fillMode;
   logic [ADDR_W-1:0] srcAddr;
   logic [ADDR_W-1:0] dstAddr;
   logic [ADDR_W:0]   length;
   logic [DATA_W-1:0] fillValue;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W-1:0] memoryAddy;
   logic [DATA_W-1:0] writeData;
   logic              cu_writeEnable;
   logic              cu_readEnable;
   logic [DATA_W-1:0] dataRAMOutput;

   modport master (
      input  start, fillMode, srcAddr, dstAddr, length, fillValue, dataRAMOutput,
      output busy, done, error, memoryAddy, writeData, cu_writeEnable, cu_readEnable
   );

   modport slave (
      output start, fillMode, srcAddr, dstAddr, length, fillValue, dataRAMOutput,
      input  busy, done, error, memoryAddy, writeData, cu_writeEnable, cu_readEnable
   );
endinterface

// File: rtl/data_mem_block_mover.sv
// Block copy / fill engine owning the data-memory port while busy.
// Every memory-side output is registered so it is stable at the falling-edge sample.
module data_mem_block_mover #(
   parameter int MEM_WORDS = 31,
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 32
) (
   input logic                    clock,
   input logic                    reset,
   data_mem_block_mover_if.master bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} stateType;

   localparam logic [ADDR_W+1:0] MEM_LIMIT = (ADDR_W+2)'(MEM_WORDS);
   localparam logic [ADDR_W:0]   ONE_COUNT = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

   stateType          state, stateNext;
   logic              rejectPending, rejectPendingNext;
   logic [ADDR_W-1:0] srcPtr, srcPtrNext;
   logic [ADDR_W-1:0] dstPtr, dstPtrNext;
   logic [ADDR_W:0]   remaining, remainingNext;
   logic              descending, descendingNext;
   logic              fillLatched, fillLatchedNext;
   logic              busyReg, busyNext;
   logic              doneReg, doneNext;
   logic              errorReg, errorNext;
   logic              writeEnReg, writeEnNext;
   logic              readEnReg, readEnNext;
   logic [ADDR_W-1:0] addrReg, addrNext;
   logic [DATA_W-1:0] dataReg, dataNext;

   logic [ADDR_W+1:0] srcEnd, dstEnd;
   logic              rangeBad, startDescending;
   logic [ADDR_W-1:0] srcFirst, dstFirst, srcStep, dstStep;

   // Sums are two bits wider than an address so an oversize range can never wrap.
   assign srcEnd          = {2'b00, bus.srcAddr} + {1'b0, bus.length};
   assign dstEnd          = {2'b00, bus.dstAddr} + {1'b0, bus.length};
   assign rangeBad        = (!bus.fillMode && (srcEnd > MEM_LIMIT)) || (dstEnd > MEM_LIMIT);
   assign startDescending = !bus.fillMode && (bus.dstAddr > bus.srcAddr);
   assign srcFirst = startDescending ? bus.srcAddr + ADDR_W'(bus.length) - ONE_ADDR : bus.srcAddr;
   assign dstFirst = startDescending ? bus.dstAddr + ADDR_W'(bus.length) - ONE_ADDR : bus.dstAddr;
   assign srcStep  = descending ? srcPtr - ONE_ADDR : srcPtr + ONE_ADDR;
   assign dstStep  = descending ? dstPtr - ONE_ADDR : dstPtr + ONE_ADDR;

   always_comb begin
      stateNext         = state;
      rejectPendingNext = 1'b0;
      srcPtrNext        = srcPtr;
      dstPtrNext        = dstPtr;
      remainingNext     = remaining;
      descendingNext    = descending;
      fillLatchedNext   = fillLatched;
      busyNext          = 1'b0;
      doneNext          = 1'b0;
      errorNext         = errorReg;
      writeEnNext       = 1'b0;
      readEnNext        = 1'b0;
      addrNext          = addrReg;
      dataNext          = dataReg;

      case (state)
         IDLE: begin
            if (bus.start) begin
               // Zero-length and rejected requests spend an extra FINISH cycle so done lands one edge after start.
               if (bus.length == '0) begin
                  stateNext         = FINISH;
                  rejectPendingNext = 1'b1;
                  errorNext         = 1'b0;
               end else if (rangeBad) begin
                  stateNext         = FINISH;
                  rejectPendingNext = 1'b1;
                  errorNext         = 1'b1;
               end else begin
                  errorNext       = 1'b0;
                  busyNext        = 1'b1;
                  fillLatchedNext = bus.fillMode;
                  descendingNext  = startDescending;
                  remainingNext   = bus.length;
                  srcPtrNext      = srcFirst;
                  dstPtrNext      = dstFirst;
                  if (bus.fillMode) begin
                     stateNext   = WRITE;
                     writeEnNext = 1'b1;
                     addrNext    = dstFirst;
                     dataNext    = bus.fillValue;
                  end else begin
                     stateNext  = READ;
                     readEnNext = 1'b1;
                     addrNext   = srcFirst;
                  end
               end
            end
         end

         READ: begin
            stateNext   = WRITE;
            busyNext    = 1'b1;
            writeEnNext = 1'b1;
            addrNext    = dstPtr;
            dataNext    = bus.dataRAMOutput;
         end

         WRITE: begin
            remainingNext = remaining - ONE_COUNT;
            srcPtrNext    = srcStep;
            dstPtrNext    = dstStep;
            if (remaining > ONE_COUNT) begin
               busyNext = 1'b1;
               if (fillLatched) begin
                  writeEnNext = 1'b1;
                  addrNext    = dstStep;
               end else begin
                  stateNext  = READ;
                  readEnNext = 1'b1;
                  addrNext   = srcStep;
               end
            end else begin
               stateNext = FINISH;
               doneNext  = 1'b1;
               addrNext  = '0;
            end
         end

         FINISH: begin
            addrNext = '0;
            if (rejectPending) begin
               doneNext = 1'b1;
            end else begin
               stateNext = IDLE;
            end
         end

         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         rejectPending <= 1'b0;
         srcPtr        <= '0;
         dstPtr        <= '0;
         remaining     <= '0;
         descending    <= 1'b0;
         fillLatched   <= 1'b0;
         busyReg       <= 1'b0;
         doneReg       <= 1'b0;
         errorReg      <= 1'b0;
         writeEnReg    <= 1'b0;
         readEnReg     <= 1'b0;
         addrReg       <= '0;
         dataReg       <= '0;
      end else begin
         state         <= stateNext;
         rejectPending <= rejectPendingNext;
         srcPtr        <= srcPtrNext;
         dstPtr        <= dstPtrNext;
         remaining     <= remainingNext;
         descending    <= descendingNext;
         fillLatched   <= fillLatchedNext;
         busyReg       <= busyNext;
         doneReg       <= doneNext;
         errorReg      <= errorNext;
         writeEnReg    <= writeEnNext;
         readEnReg     <= readEnNext;
         addrReg       <= addrNext;
         dataReg       <= dataNext;
      end
   end

   assign bus.busy           = busyReg;
   assign bus.done           = doneReg;
   assign bus.error          = errorReg;
   assign bus.cu_writeEnable = writeEnReg;
   assign bus.cu_readEnable  = readEnReg;
   assign bus.memoryAddy     = addrReg;
   assign bus.writeData      = dataReg;
endmodule

// File: tb/tb_data_mem_block_mover.sv
// Randomized bench for data_mem_block_mover: a falling-edge memory model plus
// an array-level memmove/fill reference and timing expectations.
module tb_data_mem_block_mover;
   localparam int MEM_WORDS = 31;
   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 32;

   logic clock = 1'b0;
   logic reset = 1'b0;

   data_mem_block_mover_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   data_mem_block_mover #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [DATA_W-1:0] mem    [MEM_WORDS];
   logic [DATA_W-1:0] refMem [MEM_WORDS];
   bit memInit = 1'b1;
   int overlapCnt = 0, readCnt = 0, writeCnt = 0, busyCnt = 0, oobCnt = 0;
   int checkCount = 0, passCount = 0;

   // Memory samples address/strobes on the falling edge; read data then holds until the next one.
   always @(negedge clock) begin
      if (memInit) begin
         for (int i = 0; i < MEM_WORDS; i++) mem[i] = refMem[i];
      end else begin
         if (bus.cu_readEnable && bus.cu_writeEnable) overlapCnt++;
         if (bus.cu_readEnable) readCnt++;
         if (bus.cu_writeEnable) writeCnt++;
         if (bus.busy) busyCnt++;
         if ((bus.cu_readEnable || bus.cu_writeEnable) && (int'(bus.memoryAddy) >= MEM_WORDS)) begin
            oobCnt++;
         end else begin
            if (bus.cu_writeEnable) mem[bus.memoryAddy] = bus.writeData;
         end
      end
      if (bus.cu_readEnable && int'(bus.memoryAddy) < MEM_WORDS)
         bus.dataRAMOutput = mem[bus.memoryAddy];
      else
         bus.dataRAMOutput = $urandom;
   end

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got === exp) passCount++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic checkMemory(input string tag);
      for (int i = 0; i < MEM_WORDS; i++)
         checkVal($sformatf("%s mem[%0d]", tag, i), mem[i], refMem[i]);
   endtask

   task automatic driveRequest(input bit fill, input int src, input int dst, input int len,
                               input logic [DATA_W-1:0] fv);
      bus.fillMode  = fill;
      bus.srcAddr   = ADDR_W'(src);
      bus.dstAddr   = ADDR_W'(dst);
      bus.length    = (ADDR_W+1)'(len);
      bus.fillValue = fv;
      bus.start     = 1'b1;
   endtask

   task automatic runOp(input string tag, input bit fill, input int src, input int dst,
                        input int len, input logic [DATA_W-1:0] fv, input bit poke);
      bit expErr, running;
      int expLat, lat, ov0, rd0, wr0, bz0, oob0;
      logic [DATA_W-1:0] tmp[$];

      expErr  = (len != 0) && ((!fill && (src + len > MEM_WORDS)) || (dst + len > MEM_WORDS));
      running = (len != 0) && !expErr;
      expLat  = !running ? 1 : (fill ? len : 2 * len);

      @(negedge clock);
      ov0 = overlapCnt; rd0 = readCnt; wr0 = writeCnt; bz0 = busyCnt; oob0 = oobCnt;
      driveRequest(fill, src, dst, len, fv);
      @(posedge clock);
      #1 bus.start = 1'b0;
      checkVal({tag, " busyAfterStart"}, bus.busy, running);

      lat = 0;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clock);
         #1;
         if (bus.done) begin
            lat = k;
            break;
         end
         // A start pulsed mid-transfer with junk operands must change nothing.
         if (poke && k == 2) begin
            driveRequest($urandom_range(0, 1), $urandom_range(0, 1023), $urandom_range(0, 1023),
                         $urandom_range(0, 2047), $urandom);
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
      if (lat == 0) checkVal({tag, " doneTimeout"}, 0, 1);
      checkVal({tag, " latency"}, lat, expLat);
      checkVal({tag, " errorAtDone"}, bus.error, expErr);
      checkVal({tag, " busyAtDone"}, bus.busy, 0);
      checkVal({tag, " enablesAtDone"}, {bus.cu_readEnable, bus.cu_writeEnable}, 0);

      @(posedge clock);
      #1;
      checkVal({tag, " donePulse"}, bus.done, 0);
      checkVal({tag, " errorHold"}, bus.error, expErr);
      checkVal({tag, " enableOverlap"}, overlapCnt - ov0, 0);
      checkVal({tag, " addrRange"}, oobCnt - oob0, 0);
      checkVal({tag, " readCount"}, readCnt - rd0, (running && !fill) ? len : 0);
      checkVal({tag, " writeCount"}, writeCnt - wr0, running ? len : 0);
      checkVal({tag, " busyCycles"}, busyCnt - bz0, running ? expLat : 0);

      if (running) begin
         if (fill) begin
            for (int i = 0; i < len; i++) refMem[dst + i] = fv;
         end else begin
            for (int i = 0; i < len; i++) tmp.push_back(refMem[src + i]);
            for (int i = 0; i < len; i++) refMem[dst + i] = tmp[i];
         end
      end
      checkMemory(tag);
   endtask

   initial begin
      int r, len, src, dst;
      bus.start = 1'b0; bus.fillMode = 1'b0; bus.srcAddr = '0; bus.dstAddr = '0;
      bus.length = '0; bus.fillValue = '0;
      for (int i = 0; i < MEM_WORDS; i++) refMem[i] = $urandom;

      repeat (2) @(posedge clock);
      #1;
      checkVal("reset busy", bus.busy, 0);
      checkVal("reset done", bus.done, 0);
      checkVal("reset error", bus.error, 0);
      checkVal("reset enables", {bus.cu_readEnable, bus.cu_writeEnable}, 0);
      checkVal("reset addr", bus.memoryAddy, 0);
      checkVal("reset wdata", bus.writeData, 0);
      memInit = 1'b0;
      @(negedge clock);
      reset = 1'b1;

      runOp("copyBasic", 0, 2, 10, 4, '0, 0);
      runOp("copyOverlap", 0, 0, 2, 5, '0, 0);
      runOp("fillBasic", 1, 0, 20, 3, 32'hDEADBEEF, 0);
      runOp("rangeErr", 0, 28, 0, 5, '0, 0);
      runOp("dstErr", 0, 0, 27, 5, '0, 0);
      runOp("zeroLen", 0, 3, 4, 0, '0, 0);
      runOp("wideErr", 0, 1023, 0, 2047, '0, 0);
      runOp("exactFit", 0, 0, 27, 4, '0, 0);
      runOp("overlapDown", 0, 5, 3, 6, '0, 0);
      runOp("midStart", 0, 3, 15, 6, '0, 1);
      runOp("fillPoke", 1, 0, 8, 7, 32'h0BADF00D, 1);

      for (int n = 0; n < 40; n++) begin
         r   = $urandom_range(0, 9);
         len = $urandom_range(1, 10);
         if (r <= 3) begin
            src = $urandom_range(0, MEM_WORDS - len);
            dst = $urandom_range(0, MEM_WORDS - len);
            runOp("rndCopy", 0, src, dst, len, '0, r == 0);
         end else if (r <= 5) begin
            src = $urandom_range(0, MEM_WORDS - len - 3);
            dst = src + $urandom_range(0, 3);
            runOp("rndOverlap", 0, src, dst, len, '0, 0);
         end else if (r <= 7) begin
            dst = $urandom_range(0, MEM_WORDS - len);
            runOp("rndFill", 1, 0, dst, len, $urandom, r == 6);
         end else if (r == 8) begin
            src = $urandom_range(MEM_WORDS - len + 1, MEM_WORDS + 5);
            runOp("rndErr", 0, src, $urandom_range(0, MEM_WORDS - len), len, '0, 0);
         end else begin
            runOp("rndZero", $urandom_range(0, 1), $urandom_range(0, 30), $urandom_range(0, 30), 0, $urandom, 0);
         end
      end

      // Reset during the third word of an ascending 6-word copy.
      @(negedge clock);
      driveRequest(0, 20, 5, 6, '0);
      @(posedge clock);
      #1 bus.start = 1'b0;
      repeat (4) @(posedge clock);
      #1 reset = 1'b0;
      #1;
      checkVal("midReset busy", bus.busy, 0);
      checkVal("midReset done", bus.done, 0);
      checkVal("midReset error", bus.error, 0);
      checkVal("midReset enables", {bus.cu_readEnable, bus.cu_writeEnable}, 0);
      checkVal("midReset addr", bus.memoryAddy, 0);
      checkVal("midReset wdata", bus.writeData, 0);
      for (int i = 0; i < 2; i++) refMem[5 + i] = refMem[20 + i];
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      checkMemory("midReset");
      runOp("afterReset", 0, 10, 0, 6, '0, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule

// File: doc/data_mem_block_mover.md
# data_mem_block_mover

Bus-initiator engine that drives the data memory's single access port (address, write data, read/write enables, read data return) to copy a block of words from one address range to another, or to fill a range with a constant. Sits between the control unit and the data memory. Takes ownership of the memory port while `busy` is high and returns it with all enables low when finished. All memory-side outputs are registered on the rising edge, so each access is stable when the memory samples on the falling edge.

## Interface
- `MEM_WORDS`, default 31: number of valid memory words (addresses 0..MEM_WORDS-1).
- `ADDR_W`, default 10: memory address width.
- `DATA_W`, default 32: memory word width.

- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `fillMode`  in  1  at start: 1 = fill, 0 = copy.
- `srcAddr`  in  ADDR_W  copy source base, sampled at start.
- `dstAddr`  in  ADDR_W  destination base, sampled at start.
- `length`  in  ADDR_W+1  word count, sampled at start.
- `fillValue`  in  DATA_W  fill word, sampled at start.
- `busy`  out  1  high while owning the memory port.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  valid with `done`: range rejected, no access performed.
- `memoryAddy`  out  ADDR_W  memory address.
- `writeData`  out  DATA_W  memory write data.
- `cu_writeEnable`  out  1  memory write strobe.
- `cu_readEnable`  out  1  memory read strobe.
- `dataRAMOutput`  in  DATA_W  memory read data.

## Operation
- States: IDLE, READ, WRITE, FINISH.
- IDLE + `start`:
  - `length`==0 → FINISH with `error`=0.
  - Copy with `srcAddr+length > MEM_WORDS`, or `dstAddr+length > MEM_WORDS` (ADDR_W+2-bit sum, no wrap) → FINISH with `error`=1.
  - Otherwise latch operands, set `busy`, and go to READ (copy) or WRITE (fill).
- Copy direction:
  - If `dstAddr > srcAddr`, walk descending from offset length-1 to 0, so overlapping moves are correct (memmove semantics).
  - Otherwise walk ascending.
- READ: drive `memoryAddy`=current source, `cu_readEnable`=1, `cu_writeEnable`=0. Next edge: capture `dataRAMOutput` into `writeData`, go to WRITE.
- WRITE: drive `memoryAddy`=current destination, `cu_writeEnable`=1, `cu_readEnable`=0, with `writeData` set to the captured word or `fillValue`. Next edge: decrement the remaining count and step the pointers. If words remain, go to READ (copy) or stay in WRITE (fill); otherwise go to FINISH.
- FINISH (one cycle): `done`=1, `busy`=0, both enables 0, then IDLE. `error` holds until the next accepted `start`.
- Enables are never high simultaneously. Both are 0 in IDLE and FINISH.
- `start` while not in IDLE is ignored. Operands change only on an accepted `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `cu_writeEnable`=0, `cu_readEnable`=0, `memoryAddy`=0, `writeData`=0; state IDLE.
- Reset asserted mid-transfer clears all outputs immediately (asynchronous). Words already written stay written. No resume.
- `start` sampled at edge T0:
  - Copy of N words: READ/WRITE alternate over cycles T0..T2N-1. `done` is high during the cycle after edge T2N. Throughput is 2 cycles/word.
  - Fill of N words: WRITE during T0..TN-1; `done` after edge TN. Throughput is 1 cycle/word.
  - Zero length or error: `done` after edge T1; `busy` never rises.
- Read data is valid after the falling edge inside the READ cycle and is captured at the following rising edge.
- A new `start` is accepted at the earliest in the cycle after FINISH.

## Test plan
- Copy, src=2, dst=10, len=4, memory[2..5]=A,B,C,D: memory[10..13]=A,B,C,D; `done` pulses 8 cycles after start; never two enables high at once.
- Overlapping copy, src=0, dst=2, len=5, memory[0..4]=1..5: memory[2..6]=1..5 (descending order); memory[0..1] unchanged.
- Fill, dst=20, len=3, fillValue=0xDEADBEEF: memory[20..22]=0xDEADBEEF; `done` 3 cycles after start; `cu_readEnable` stays 0.
- Range error, src=28, len=5 (MEM_WORDS=31): `done`=1 and `error`=1 one cycle after start; zero enables asserted; memory untouched.
- `length`=0 and `start` pulsed while busy: zero-length gives `done` with `error`=0; a `start` mid-transfer does not alter operands or timing.
- Reset pulled low during the 3rd word of a 6-word copy: outputs go to 0 immediately; first 2 words copied, remainder untouched; a new `start` after reset runs normally.
